// File: rtl/axi_pkg.sv
// axi_pkg: shared definitions for the 2-master AXI write-path scheduler.
//   MASTER_NUM  : number of requesting masters (only 2 supported)
//   ORDER_DEPTH : default depth of the W/B order queues
//   master_id_t : master index as stored in the order queues
//   onehot_id() : master index -> one-hot select vector
package axi_pkg;

    localparam int MASTER_NUM  = 2;
    localparam int ORDER_DEPTH = 4;

    typedef logic [0:0] master_id_t;

    function automatic logic [MASTER_NUM-1:0] onehot_id(input master_id_t id);
        onehot_id     = '0;
        onehot_id[id] = 1'b1;
    endfunction

endpackage

// File: rtl/axi_wr_sched_if.sv
// axi_wr_sched_if: VALID/READY/LAST handshake bundle plus mux selects
// around the write scheduler.
//   *_M : per-master side (one bit per master)
//   *_S : slave side (single channel toward the decoder/mux)
//   *_SEL : one-hot mux/demux selects, 00 = none
// Modports:
//   slave  : the scheduler's view
//   master : the view of the surrounding ports (or a testbench)
interface axi_wr_sched_if;
    import axi_pkg::*;

    logic [MASTER_NUM-1:0] AWVALID_M;
    logic [MASTER_NUM-1:0] AWREADY_M;
    logic                  AWVALID_S;
    logic                  AWREADY_S;
    logic [MASTER_NUM-1:0] AW_SEL;

    logic [MASTER_NUM-1:0] WVALID_M;
    logic [MASTER_NUM-1:0] WLAST_M;
    logic [MASTER_NUM-1:0] WREADY_M;
    logic                  WVALID_S;
    logic                  WREADY_S;
    logic [MASTER_NUM-1:0] W_SEL;

    logic                  BVALID_S;
    logic                  BREADY_S;
    logic [MASTER_NUM-1:0] BVALID_M;
    logic [MASTER_NUM-1:0] BREADY_M;
    logic [MASTER_NUM-1:0] B_SEL;

    modport slave (
        input  AWVALID_M, AWREADY_S, WVALID_M, WLAST_M, WREADY_S, BVALID_S, BREADY_M,
        output AWREADY_M, AWVALID_S, AW_SEL, WREADY_M, WVALID_S, W_SEL,
               BREADY_S, BVALID_M, B_SEL
    );

    modport master (
        output AWVALID_M, AWREADY_S, WVALID_M, WLAST_M, WREADY_S, BVALID_S, BREADY_M,
        input  AWREADY_M, AWVALID_S, AW_SEL, WREADY_M, WVALID_S, W_SEL,
               BREADY_S, BVALID_M, B_SEL
    );

endinterface

// File: rtl/axi_wr_sched_order_fifo.sv
// order_fifo: small FIFO of master indices recording AW grant order.
//   ACLK, ARESETn : clock, async active-low reset (empties the queue)
//   push, din     : enqueue din (ignored when full)
//   pop           : dequeue head (ignored when empty)
//   head          : oldest entry, valid only when !empty
//   full, empty   : occupancy flags
// No bypass: an entry pushed into an empty queue appears the next cycle.
module order_fifo
    import axi_pkg::*;
#(
    parameter int DEPTH = ORDER_DEPTH
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       push,
    input  logic       pop,
    input  master_id_t din,
    output master_id_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    master_id_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: head is only consumed while non-empty.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_sched.sv
// axi_wr_sched: write-path scheduler for a 2-master AXI interconnect.
//   ACLK, ARESETn : clock, async active-low reset
//   bus (slave)   : AW arbitration (round-robin, locked until handshake),
//                   W steering to the owner of the oldest open burst,
//                   B steering to the owner of the oldest outstanding write.
// Only selects and VALID/READY gating are produced; payloads bypass.
module axi_wr_sched #(
    parameter int MASTER_NUM = axi_pkg::MASTER_NUM,
    parameter int DEPTH      = axi_pkg::ORDER_DEPTH
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    axi_wr_sched_if.slave  bus
);
    import axi_pkg::*;

    logic       lock;
    master_id_t lock_id;
    master_id_t prio;

    master_id_t grant;
    logic       grant_vld;
    logic [MASTER_NUM-1:0] grant_oh;
    logic       aw_ok;
    logic       aw_hs;

    master_id_t wq_head;
    logic       wq_full;
    logic       wq_empty;
    logic       w_pop;
    logic [MASTER_NUM-1:0] w_sel;

    master_id_t bq_head;
    logic       bq_full;
    logic       bq_empty;
    logic       b_pop;
    logic [MASTER_NUM-1:0] b_sel;

    // Grant depends only on AWVALID_M and registered state, never on
    // AWREADY_S. ARESETn gating keeps AW outputs at 0 while reset is held
    // even if masters still assert AWVALID.
    always_comb begin
        grant     = prio;
        grant_vld = 1'b0;
        if (!ARESETn) begin
            grant_vld = 1'b0;
        end else if (lock) begin
            grant     = lock_id;
            grant_vld = |bus.AWVALID_M;
        end else if (bus.AWVALID_M[prio]) begin
            grant     = prio;
            grant_vld = 1'b1;
        end else if (bus.AWVALID_M[~prio]) begin
            grant     = ~prio;
            grant_vld = 1'b1;
        end
    end

    assign grant_oh      = grant_vld ? onehot_id(grant) : '0;
    assign aw_ok         = ~wq_full & ~bq_full;
    assign bus.AW_SEL    = grant_oh;
    assign bus.AWVALID_S = grant_vld & bus.AWVALID_M[grant] & aw_ok;
    assign bus.AWREADY_M = grant_oh & {MASTER_NUM{bus.AWREADY_S & aw_ok}};
    assign aw_hs         = bus.AWVALID_S & bus.AWREADY_S;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lock    <= 1'b0;
            lock_id <= '0;
            prio    <= '0;
        end else if (aw_hs) begin
            lock <= 1'b0;
            prio <= ~grant;
        end else if (bus.AWVALID_S) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    order_fifo #(.DEPTH(DEPTH)) u_wq (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (aw_hs),
        .pop     (w_pop),
        .din     (grant),
        .head    (wq_head),
        .full    (wq_full),
        .empty   (wq_empty)
    );

    order_fifo #(.DEPTH(DEPTH)) u_bq (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (aw_hs),
        .pop     (b_pop),
        .din     (grant),
        .head    (bq_head),
        .full    (bq_full),
        .empty   (bq_empty)
    );

    // W steering: the head switches at the WLAST edge, so back-to-back
    // bursts from different masters run without a bubble.
    assign w_sel         = wq_empty ? '0 : onehot_id(wq_head);
    assign bus.W_SEL     = w_sel;
    assign bus.WVALID_S  = ~wq_empty & bus.WVALID_M[wq_head];
    assign bus.WREADY_M  = w_sel & {MASTER_NUM{bus.WREADY_S}};
    assign w_pop         = bus.WVALID_S & bus.WREADY_S & bus.WLAST_M[wq_head];

    // B steering.
    assign b_sel         = bq_empty ? '0 : onehot_id(bq_head);
    assign bus.B_SEL     = b_sel;
    assign bus.BVALID_M  = b_sel & {MASTER_NUM{bus.BVALID_S}};
    assign bus.BREADY_S  = ~bq_empty & bus.BREADY_M[bq_head];
    assign b_pop         = bus.BVALID_S & bus.BREADY_S;

endmodule

// File: tb/tb_axi_wr_sched.sv
// tb_axi_wr_sched: self-checking bench for axi_wr_sched.
// Directed AW steps push the expected master index into W/B scoreboards;
// a negedge monitor pops them on W/B handshakes and checks the routing.
module tb_axi_wr_sched;

    logic ACLK;
    logic ARESETn;

    axi_wr_sched_if bus ();

    axi_wr_sched #(.MASTER_NUM(2), .DEPTH(4)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    int unsigned n_checks;
    int unsigned n_fail;
    bit          w_exp [$];
    bit          b_exp [$];

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input bit id);
        oh = id ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {bus.AW_SEL, bus.AWREADY_M, bus.AWVALID_S, bus.W_SEL, bus.WREADY_M,
                       bus.WVALID_S, bus.B_SEL, bus.BVALID_M, bus.BREADY_S}, 32'd0);
    endtask

    // One AW cycle: drive, check at negedge, record expected owner on handshake.
    task automatic aw_step(input string tag, input logic [1:0] vld, input logic rdy,
                           input logic [1:0] exp_sel, input logic exp_vs);
        bus.AWVALID_M = vld;
        bus.AWREADY_S = rdy;
        @(negedge ACLK);
        check_eq({tag, "_sel"}, bus.AW_SEL, exp_sel);
        check_eq({tag, "_vs"}, bus.AWVALID_S, exp_vs);
        check_eq({tag, "_rdym"}, bus.AWREADY_M, exp_vs ? (exp_sel & {2{rdy}}) : 2'b00);
        #1;
        if (exp_vs && rdy) begin
            w_exp.push_back(exp_sel[1]);
            b_exp.push_back(exp_sel[1]);
        end
        tick();
    endtask

    task automatic drain_w(input int n);
        bus.WVALID_M = 2'b11;
        bus.WLAST_M  = 2'b11;
        bus.WREADY_S = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            check_eq("drain_w_vs", bus.WVALID_S, 1);
            tick();
        end
        bus.WVALID_M = 2'b00;
        bus.WLAST_M  = 2'b00;
        bus.WREADY_S = 1'b0;
    endtask

    task automatic drain_b(input int n);
        bus.BVALID_S = 1'b1;
        bus.BREADY_M = 2'b11;
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            check_eq("drain_b_rs", bus.BREADY_S, 1);
            tick();
        end
        bus.BVALID_S = 1'b0;
        bus.BREADY_M = 2'b00;
    endtask

    // Scoreboard monitor.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (bus.WVALID_S && bus.WREADY_S) begin
                if (w_exp.size() == 0) begin
                    check_eq("w_unexpected_sel", bus.W_SEL, 2'b00);
                end else begin
                    check_eq("w_route", bus.W_SEL, oh(w_exp[0]));
                    check_eq("w_ready_route", bus.WREADY_M, oh(w_exp[0]));
                    if (bus.WLAST_M[w_exp[0]]) begin
                        void'(w_exp.pop_front());
                    end
                end
            end
            if (bus.BVALID_S && bus.BREADY_S) begin
                if (b_exp.size() == 0) begin
                    check_eq("b_unexpected_sel", bus.B_SEL, 2'b00);
                end else begin
                    check_eq("b_route", bus.B_SEL, oh(b_exp[0]));
                    check_eq("b_valid_route", bus.BVALID_M, oh(b_exp[0]));
                    void'(b_exp.pop_front());
                end
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        ARESETn       = 1'b0;
        bus.AWVALID_M = 2'b11;
        bus.AWREADY_S = 1'b1;
        bus.WVALID_M  = 2'b11;
        bus.WLAST_M   = 2'b00;
        bus.WREADY_S  = 1'b1;
        bus.BVALID_S  = 1'b1;
        bus.BREADY_M  = 2'b11;
        #3;
        check_all_zero("reset_outputs");
        bus.AWVALID_M = 2'b00;
        bus.WVALID_M  = 2'b00;
        bus.WREADY_S  = 1'b0;
        bus.BVALID_S  = 1'b0;
        bus.BREADY_M  = 2'b00;
        tick();
        tick();
        ARESETn = 1'b1;
        tick();

        // Contention: alternating grants, stall when queues fill.
        aw_step("cont0", 2'b11, 1'b1, 2'b01, 1'b1);
        aw_step("cont1", 2'b11, 1'b1, 2'b10, 1'b1);
        aw_step("cont2", 2'b11, 1'b1, 2'b01, 1'b1);
        aw_step("cont3", 2'b11, 1'b1, 2'b10, 1'b1);
        aw_step("cont_full", 2'b11, 1'b1, 2'b01, 1'b0);
        bus.AWVALID_M = 2'b00;
        drain_w(4);

        // B stall, then drain one and refill with a wrapping write.
        bus.BVALID_S = 1'b1;
        bus.BREADY_M = 2'b00;
        @(negedge ACLK);
        check_eq("b_stall_rs", bus.BREADY_S, 0);
        check_eq("b_stall_vm", bus.BVALID_M, 2'b01);
        tick();
        drain_b(1);
        aw_step("wrap_aw", 2'b01, 1'b1, 2'b01, 1'b1);
        aw_step("bq_full", 2'b10, 1'b1, 2'b10, 1'b0);
        bus.AWVALID_M = 2'b00;
        drain_b(4);
        drain_w(1);

        // Lock: M1 waits 3 cycles while M0 raises valid.
        aw_step("pre_lock", 2'b10, 1'b1, 2'b10, 1'b1);
        aw_step("lock0", 2'b10, 1'b0, 2'b10, 1'b1);
        aw_step("lock1", 2'b11, 1'b0, 2'b10, 1'b1);
        aw_step("lock2", 2'b11, 1'b0, 2'b10, 1'b1);
        aw_step("lock_hs", 2'b11, 1'b1, 2'b10, 1'b1);
        aw_step("after_lock", 2'b11, 1'b1, 2'b01, 1'b1);
        bus.AWVALID_M = 2'b00;
        drain_w(3);
        drain_b(3);

        // W ordering: AW M0 then M1; M1 drives W first.
        bus.AWVALID_M = 2'b01;
        bus.AWREADY_S = 1'b1;
        bus.WVALID_M  = 2'b01;
        bus.WREADY_S  = 1'b1;
        @(negedge ACLK);
        check_eq("wo_aw0_sel", bus.AW_SEL, 2'b01);
        check_eq("wo_no_bypass_wsel", bus.W_SEL, 2'b00);
        check_eq("wo_no_bypass_wvs", bus.WVALID_S, 0);
        #1;
        w_exp.push_back(1'b0);
        b_exp.push_back(1'b0);
        tick();
        bus.AWVALID_M = 2'b10;
        bus.WVALID_M  = 2'b10;
        @(negedge ACLK);
        check_eq("wo_aw1_sel", bus.AW_SEL, 2'b10);
        check_eq("wo_wready_m", bus.WREADY_M, 2'b01);
        check_eq("wo_wvs_blocked", bus.WVALID_S, 0);
        #1;
        w_exp.push_back(1'b1);
        b_exp.push_back(1'b1);
        tick();
        bus.AWVALID_M = 2'b00;
        bus.WVALID_M  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.WLAST_M = (i == 3) ? 2'b01 : 2'b00;
            @(negedge ACLK);
            check_eq("wo_m0_beat_sel", bus.W_SEL, 2'b01);
            tick();
        end
        bus.WLAST_M = 2'b10;
        @(negedge ACLK);
        check_eq("wo_switch_sel", bus.W_SEL, 2'b10);
        check_eq("wo_switch_vs", bus.WVALID_S, 1);
        tick();
        bus.WVALID_M = 2'b00;
        bus.WLAST_M  = 2'b00;
        bus.WREADY_S = 1'b0;
        drain_b(2);

        // B routing: outstanding M1 then M0.
        aw_step("br_aw1", 2'b10, 1'b1, 2'b10, 1'b1);
        aw_step("br_aw0", 2'b01, 1'b1, 2'b01, 1'b1);
        bus.AWVALID_M = 2'b00;
        drain_w(2);
        bus.BVALID_S = 1'b1;
        bus.BREADY_M = 2'b00;
        @(negedge ACLK);
        check_eq("br_stall_rs", bus.BREADY_S, 0);
        check_eq("br_first_vm", bus.BVALID_M, 2'b10);
        tick();
        bus.BREADY_M = 2'b10;
        @(negedge ACLK);
        check_eq("br_first_rs", bus.BREADY_S, 1);
        tick();
        bus.BREADY_M = 2'b00;
        @(negedge ACLK);
        check_eq("br_second_vm", bus.BVALID_M, 2'b01);
        tick();
        bus.BREADY_M = 2'b01;
        tick();
        bus.BREADY_M = 2'b00;
        @(negedge ACLK);
        check_eq("br_empty_vm", bus.BVALID_M, 2'b00);
        check_eq("br_empty_sel", bus.B_SEL, 2'b00);
        tick();
        bus.BVALID_S = 1'b0;

        // Reset in the middle of a W burst.
        aw_step("rst_aw", 2'b01, 1'b1, 2'b01, 1'b1);
        bus.AWVALID_M = 2'b00;
        bus.WVALID_M  = 2'b01;
        bus.WLAST_M   = 2'b00;
        bus.WREADY_S  = 1'b1;
        tick();
        @(posedge ACLK);
        #2;
        ARESETn       = 1'b0;
        bus.AWVALID_M = 2'b11;
        bus.BVALID_S  = 1'b1;
        bus.BREADY_M  = 2'b11;
        #1;
        check_all_zero("midburst_reset_outputs");
        w_exp.delete();
        b_exp.delete();
        bus.AWVALID_M = 2'b00;
        bus.WVALID_M  = 2'b00;
        bus.WREADY_S  = 1'b0;
        bus.BVALID_S  = 1'b0;
        bus.BREADY_M  = 2'b00;
        tick();
        ARESETn = 1'b1;
        tick();
        aw_step("post_rst_aw", 2'b11, 1'b1, 2'b01, 1'b1);
        bus.AWVALID_M = 2'b00;
        drain_w(1);
        drain_b(1);

        check_eq("sb_w_left", w_exp.size(), 0);
        check_eq("sb_b_left", b_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
